// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encodings and constants for the UART program loader.
package prog_loader_pkg;
  localparam int LEN_BYTES = 4;
  typedef enum logic [2:0] {LEN = 3'd0, DATA = 3'd1, CHK = 3'd2, DONE = 3'd3, ERR = 3'd4} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: BRAM port-A write bus driven by the loader.
interface prog_loader_if;
  logic [3:0]  wea;
  logic [31:0] addra;
  logic [31:0] dia;
  modport master (output wea, addra, dia);
  modport slave  (input  wea, addra, dia);
endinterface

// File: rtl/prog_loader_uart_rx.sv
// uart_rx: synchronized 8N1 receiver with mid-bit sampling and start-bit glitch rejection.
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  rx_state_t st, st_n;
  logic [1:0] sync;
  logic prev, rx_s, tick;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  assign rx_s = sync[1];
  assign tick = cnt == ((st == RX_START) ? CW'(CLKS_PER_BIT / 2 - 1) : CW'(CLKS_PER_BIT - 1));
  always_comb begin
    st_n = st;
    case (st)
      RX_IDLE:  st_n = (prev && !rx_s) ? RX_START : RX_IDLE;
      RX_START: st_n = tick ? (rx_s ? RX_IDLE : RX_BITS) : RX_START;
      RX_BITS:  st_n = (tick && bit_idx == 3'd7) ? RX_STOP : RX_BITS;
      default:  st_n = tick ? RX_IDLE : RX_STOP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= 2'b11;
      prev <= 1'b1;
      st <= RX_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      prev <= rx_s;
      st <= st_n;
      cnt <= (st == RX_IDLE || tick) ? '0 : cnt + 1'b1;
      rx_valid <= 1'b0;
      rx_ferr <= 1'b0;
      if (st == RX_BITS && tick) begin
        rx_data <= {rx_s, rx_data[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (st == RX_STOP && tick) begin
        rx_valid <= rx_s;
        rx_ferr <= !rx_s;
      end
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed, XOR-checksummed image over UART into BRAM and releases the CPU.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int MEM_BYTES    = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                uart_rx,
  prog_loader_if.master       bram,
  output logic                cpu_rst_n,
  output logic                busy,
  output logic                load_done,
  output logic                load_err
);
  state_t state, state_n;
  logic rx_valid, rx_ferr;
  logic [7:0] rx_data, csum;
  logic [31:0] len, cnt, n_len;
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk), .rst_n(rst_n), .rx(uart_rx),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ferr(rx_ferr)
  );
  assign n_len = {rx_data, len[31:8]};
  assign busy = state == LEN || state == DATA || state == CHK;
  always_comb begin
    state_n = state;
    case (state)
      LEN:  state_n = rx_ferr ? ERR :
                      (rx_valid && cnt == 32'(LEN_BYTES - 1)) ?
                        (n_len > 32'(MEM_BYTES) ? ERR : n_len == 0 ? CHK : DATA) : LEN;
      DATA: state_n = rx_ferr ? ERR : (rx_valid && cnt == len - 32'd1) ? CHK : DATA;
      CHK:  state_n = rx_ferr ? ERR : rx_valid ? (rx_data == csum ? DONE : ERR) : CHK;
      DONE: state_n = DONE;
      default: state_n = ERR;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= LEN;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      len <= '0;
      cnt <= '0;
      csum <= '0;
      bram.wea <= '0;
      bram.addra <= '0;
      bram.dia <= '0;
      cpu_rst_n <= 1'b0;
      load_done <= 1'b0;
      load_err <= 1'b0;
    end else begin
      bram.wea <= '0;
      if (state == LEN && rx_valid) begin
        len <= n_len;
        cnt <= (cnt == 32'(LEN_BYTES - 1)) ? '0 : cnt + 32'd1;
      end
      if (state == DATA && rx_valid) begin
        bram.wea <= 4'b0001 << cnt[1:0];
        bram.addra <= {cnt[31:2], 2'b00};
        bram.dia <= {4{rx_data}};
        csum <= csum ^ rx_data;
        cnt <= cnt + 32'd1;
      end
      cpu_rst_n <= state == DONE;
      load_done <= state == DONE;
      load_err <= state == ERR;
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: random and directed image loads checked against a byte-stream reference model.
module tb_prog_loader;
  localparam int CPB = 4;
  localparam int MEM = 64;
  logic clk = 1'b0, rst_n = 1'b0, uart_rx = 1'b1;
  logic cpu_rst_n, busy, load_done, load_err;
  int n_tests = 0, n_fail = 0;
  logic [7:0] tx[$];
  int ferr_at;
  logic [67:0] got_w[$], exp_w[$];
  logic exp_done, exp_err;
  prog_loader_if bram();
  prog_loader #(.CLKS_PER_BIT(CPB), .MEM_BYTES(MEM)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .bram(bram),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .load_done(load_done), .load_err(load_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (bram.wea != 4'b0) got_w.push_back({bram.addra, bram.wea, bram.dia});
  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask
  // Walk the byte stream as the loader protocol describes: 4 LE length bytes, payload, XOR checksum.
  task automatic model();
    logic [31:0] n = 0, k;
    logic [7:0] cs = 0;
    exp_w.delete();
    exp_done = 0;
    exp_err = 0;
    for (int i = 0; i < tx.size(); i++) begin
      if (i == ferr_at) begin
        exp_err = 1;
        break;
      end
      if (i < 4) begin
        n = n | (32'(tx[i]) << (8 * i));
        if (i == 3 && n > MEM) begin
          exp_err = 1;
          break;
        end
      end else if (32'(i - 4) < n) begin
        k = 32'(i - 4);
        exp_w.push_back({k / 4 * 4, 4'(1 << (k % 4)), {4{tx[i]}}});
        cs = cs ^ tx[i];
      end else begin
        exp_done = tx[i] == cs;
        exp_err = !exp_done;
        break;
      end
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cpu_rst_n", 68'(cpu_rst_n), 68'(0));
    check("rst_busy", 68'(busy), 68'(1));
    check("rst_flags", 68'({load_done, load_err}), 68'(0));
    check("rst_bus", {bram.addra, bram.wea, bram.dia}, 68'(0));
    got_w.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic run_image(input string name);
    do_reset();
    for (int i = 0; i < tx.size(); i++) send_byte(tx[i], i != ferr_at);
    repeat (10) @(negedge clk);
    model();
    check({name, "_nwr"}, 68'(got_w.size()), 68'(exp_w.size()));
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
      check($sformatf("%s_wr%0d", name, i), got_w[i], exp_w[i]);
    check({name, "_done"}, 68'(load_done), 68'(exp_done));
    check({name, "_err"}, 68'(load_err), 68'(exp_err));
    check({name, "_cpu"}, 68'(cpu_rst_n), 68'(exp_done));
    check({name, "_busy"}, 68'(busy), 68'(!exp_done && !exp_err));
  endtask
  initial begin
    logic [7:0] cs;
    int n;
    ferr_at = -1;
    tx = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h93,
           8'h01, 8'h02, 8'h03, 8'h04, 8'h84, 8'h55, 8'hAA};
    run_image("n8");
    tx = '{8'h05, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hEE, 8'h12};
    run_image("n5");
    tx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33};
    run_image("n0");
    tx = '{8'h41, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02};
    run_image("toolong");
    tx = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'hFF};
    run_image("badchk");
    tx = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    ferr_at = 6;
    run_image("ferr");
    ferr_at = -1;
    tx = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30};
    do_reset();
    for (int i = 0; i < tx.size(); i++) send_byte(tx[i], 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_flags", 68'({load_done, load_err, cpu_rst_n, busy}), 68'(4'b0001));
    tx = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70};
    run_image("reload");
    for (int t = 0; t < 12; t++) begin
      n = ($urandom % 5 == 0) ? 65 + int'($urandom % 100) : int'($urandom % 21);
      tx = '{8'(n), 8'h00, 8'h00, 8'h00};
      cs = 0;
      if (n <= MEM) begin
        for (int i = 0; i < n; i++) begin
          tx.push_back(8'($urandom));
          cs = cs ^ tx[tx.size() - 1];
        end
        tx.push_back(($urandom % 4 == 0) ? cs ^ 8'(1 + $urandom % 255) : cs);
      end
      tx.push_back(8'($urandom));
      tx.push_back(8'($urandom));
      ferr_at = ($urandom % 4 == 0) ? int'($urandom % tx.size()) : -1;
      run_image($sformatf("rnd%0d", t));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
